// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between the
// ALU (requester 0) and the load unit (requester 1). The winning write is
// registered and presented to the register file for exactly one cycle.
module rf_write_arbiter #(
  parameter int unsigned DW  = 12,
  parameter int unsigned RFW = 2,
  parameter int unsigned CW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           hold,
  input  logic           req0,
  input  logic           req1,
  input  logic [RFW-1:0] addr0,
  input  logic [RFW-1:0] addr1,
  input  logic [DW-1:0]  data0,
  input  logic [DW-1:0]  data1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           rf_we,
  output logic [RFW-1:0] rf_wr_address,
  output logic [DW-1:0]  rf_wr_data,
  output logic           last_src,
  output logic [CW-1:0]  conflict_cnt
);

  logic           ptr_q;
  logic           rf_we_q;
  logic [RFW-1:0] rf_wr_address_q;
  logic [DW-1:0]  rf_wr_data_q;
  logic           last_src_q;
  logic [CW-1:0]  conflict_cnt_q;

  logic           win_gnt0;
  logic           win_gnt1;
  logic           any_gnt;
  logic           win_idx;
  logic [RFW-1:0] win_addr;
  logic [DW-1:0]  win_data;
  logic           conflict;

  // Grant decision: hold blocks everything, a tie goes to the pointer's favourite.
  always_comb begin
    win_gnt0 = 1'b0;
    win_gnt1 = 1'b0;
    if (!hold) begin
      if (req0 && req1) begin
        win_gnt0 = ~ptr_q;
        win_gnt1 = ptr_q;
      end else begin
        win_gnt0 = req0;
        win_gnt1 = req1;
      end
    end
    any_gnt  = win_gnt0 | win_gnt1;
    win_idx  = win_gnt1;
    win_addr = win_gnt1 ? addr1 : addr0;
    win_data = win_gnt1 ? data1 : data0;
    conflict = req0 & req1 & ~hold;
  end

  // Grants are masked while reset is asserted so requesters never consume in reset.
  assign gnt0 = win_gnt0 & rst_n;
  assign gnt1 = win_gnt1 & rst_n;

  // Pointer, registered write port and saturating conflict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q           <= 1'b0;
      rf_we_q         <= 1'b0;
      rf_wr_address_q <= '0;
      rf_wr_data_q    <= '0;
      last_src_q      <= 1'b0;
      conflict_cnt_q  <= '0;
    end else begin
      if (any_gnt) begin
        ptr_q           <= ~win_idx;
        rf_wr_address_q <= win_addr;
        rf_wr_data_q    <= win_data;
        last_src_q      <= win_idx;
      end
      // Zero-register writes are granted but never reach the register file.
      rf_we_q <= any_gnt && (win_addr != '0);
      if (conflict && (conflict_cnt_q != {CW{1'b1}})) begin
        conflict_cnt_q <= conflict_cnt_q + 1'b1;
      end
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_wr_address = rf_wr_address_q;
  assign rf_wr_data    = rf_wr_data_q;
  assign last_src      = last_src_q;
  assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: an abstract arbitration model checked every cycle,
// a negedge-committing register file, and directed scenarios with literal values.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        req0, req1;
  logic [1:0]  addr0, addr1;
  logic [11:0] data0, data1;

  logic        gnt0, gnt1, rf_we, last_src;
  logic [1:0]  rf_wr_address;
  logic [11:0] rf_wr_data;
  logic [7:0]  conflict_cnt;

  logic        s_gnt0, s_gnt1, s_rf_we, s_last_src;
  logic [1:0]  s_rf_wr_address;
  logic [11:0] s_rf_wr_data;
  logic [1:0]  s_conflict_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DW(12), .RFW(2), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .rf_we(rf_we), .rf_wr_address(rf_wr_address),
    .rf_wr_data(rf_wr_data), .last_src(last_src), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance for saturation, fed the same stimulus.
  rf_write_arbiter #(.DW(12), .RFW(2), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .rf_we(s_rf_we), .rf_wr_address(s_rf_wr_address),
    .rf_wr_data(s_rf_wr_data), .last_src(s_last_src), .conflict_cnt(s_conflict_cnt)
  );

  // Register file seen by the arbiter: commits on the falling edge.
  logic [11:0] rf [4];
  initial for (int i = 0; i < 4; i++) rf[i] = 12'h000;
  always @(negedge clk) if (rf_we) rf[rf_wr_address] <= rf_wr_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_fav;      // requester that wins the next tie
  logic        m_we;
  logic [1:0]  m_addr;
  logic [11:0] m_data;
  int          m_src;
  int          m_cnt8, m_cnt2;

  // Winner index this cycle, or -1 for nobody.
  function automatic int model_winner();
    if (hold) return -1;
    if (req0 && req1) return m_fav;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fav <= 0; m_we <= 1'b0; m_addr <= 2'd0; m_data <= 12'd0; m_src <= 0;
      m_cnt8 <= 0; m_cnt2 <= 0;
    end else begin
      if (model_winner() >= 0) begin
        m_we   <= ((model_winner() == 1) ? addr1 : addr0) != 2'd0;
        m_addr <= (model_winner() == 1) ? addr1 : addr0;
        m_data <= (model_winner() == 1) ? data1 : data0;
        m_src  <= model_winner();
        m_fav  <= 1 - model_winner();
      end else begin
        m_we <= 1'b0;
      end
      if (req0 && req1 && !hold) begin
        m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
  end

  task automatic compare_all();
    int w;
    w = rst_n ? model_winner() : -1;
    chk("gnt0", 32'(gnt0), 32'(w == 0));
    chk("gnt1", 32'(gnt1), 32'(w == 1));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_wr_address", 32'(rf_wr_address), 32'(m_addr));
    chk("rf_wr_data", 32'(rf_wr_data), 32'(m_data));
    chk("last_src", 32'(last_src), 32'(m_src));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt8));
    chk("sat_conflict_cnt", 32'(s_conflict_cnt), 32'(m_cnt2));
    chk("sat_rf_we", 32'(s_rf_we), 32'(m_we));
  endtask

  always @(negedge clk) compare_all();

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
    addr0 = 2'd0; addr1 = 2'd0; data0 = 12'h000; data1 = 12'h000;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_cnt", 32'(conflict_cnt), 32'd0);
    chk("reset_last_src", 32'(last_src), 32'd0);

    // Single request from reset.
    rst_n = 1'b1;
    req0 = 1'b1; addr0 = 2'd1; data0 = 12'h0A5;
    #1 chk("single_gnt0", 32'(gnt0), 32'd1);
    step();
    req0 = 1'b0;
    chk("single_we", 32'(rf_we), 32'd1);
    chk("single_addr", 32'(rf_wr_address), 32'd1);
    chk("single_data", 32'(rf_wr_data), 32'h0A5);
    chk("single_src", 32'(last_src), 32'd0);
    @(negedge clk);
    #1 chk("rf1_value", 32'(rf[1]), 32'h0A5);

    // Continuous dual requests from reset.
    do_reset();
    req0 = 1'b1; addr0 = 2'd2; data0 = 12'h111;
    req1 = 1'b1; addr1 = 2'd3; data1 = 12'h222;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_order", 32'(gnt1), 32'(i % 2));
      step();
      chk("rr_we", 32'(rf_we), 32'd1);
      chk("rr_src", 32'(last_src), 32'(i % 2));
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_cnt", 32'(conflict_cnt), 32'd4);

    // Zero register.
    req1 = 1'b1; addr1 = 2'd0; data1 = 12'hFFF;
    #1 chk("zero_gnt1", 32'(gnt1), 32'd1);
    step();
    req1 = 1'b0;
    chk("zero_we", 32'(rf_we), 32'd0);
    chk("zero_src", 32'(last_src), 32'd1);
    chk("zero_data", 32'(rf_wr_data), 32'hFFF);
    @(negedge clk);
    #1 chk("rf0_value", 32'(rf[0]), 32'h000);

    // Hold with both requesting.
    step();
    hold = 1'b1;
    req0 = 1'b1; addr0 = 2'd2; data0 = 12'h111;
    req1 = 1'b1; addr1 = 2'd3; data1 = 12'h222;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_gnt", 32'({gnt1, gnt0}), 32'd0);
      step();
      chk("hold_we", 32'(rf_we), 32'd0);
    end
    chk("hold_cnt", 32'(conflict_cnt), 32'd4);
    hold = 1'b0;
    #1 chk("unhold_gnt0", 32'(gnt0), 32'd1);
    step();
    #1 chk("unhold_next_gnt1", 32'(gnt1), 32'd1);
    step();
    req0 = 1'b0; req1 = 1'b0;

    // Saturation of the narrow counter.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    repeat (6) step();
    req0 = 1'b0; req1 = 1'b0;
    chk("sat_cnt2", 32'(s_conflict_cnt), 32'd3);
    chk("sat_cnt8", 32'(conflict_cnt), 32'd6);

    // Reset right after a grant loses the registered write.
    do_reset();
    req0 = 1'b1; addr0 = 2'd3; data0 = 12'h5A5;
    step();
    req0 = 1'b0;
    chk("midrst_we_before", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1 chk("midrst_we_dropped", 32'(rf_we), 32'd0);
    chk("midrst_gnt_low", 32'({gnt1, gnt0}), 32'd0);
    @(negedge clk);
    #1 chk("midrst_rf3", 32'(rf[3]), 32'h222);
    step();
    rst_n = 1'b1;
    req0 = 1'b1; addr0 = 2'd1; req1 = 1'b1; addr1 = 2'd2;
    #1 chk("midrst_tie_gnt0", 32'(gnt0), 32'd1);
    step();
    idle_inputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
